// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: pipeline controller that sits beside the EX stage of the
// 5-stage MIPS core. It stalls the front end on load-use hazards, picks the
// forwarding source for both ALU operands, redirects the PC on a taken beq,
// and holds the pipe while a multi-cycle EX operation runs.
//
// Build option: define EX_HAZARD_FWD_EN to enable operand forwarding. When it
// is left undefined, fwd_a/fwd_b stay 0. Instead, any read-after-write between
// an ID operand and a pending write in EX, MEM or WB stalls the front end
// until that write has retired.
module ex_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       fd_rs,
    input  logic [4:0]       fd_rt,
    input  logic             fd_use_rt,
    input  logic [4:0]       dx_rs,
    input  logic [4:0]       dx_rt,
    input  logic [4:0]       DX_RD,
    input  logic             DX_lwFlag,
    input  logic [4:0]       XM_RD,
    input  logic             XM_regwrite,
    input  logic [4:0]       MW_RD,
    input  logic             MW_regwrite,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             mul_start,
    output logic             pc_stall,
    output logic             fd_stall,
    output logic             fd_flush,
    output logic             dx_bubble,
    output logic             dx_hold,
    output logic             pc_redirect,
    output logic [31:0]      pc_target,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        MULWAIT = 1'b1
    } state_t;

    state_t           r_state;
    logic [3:0]       r_mcnt;
    logic [CNT_W-1:0] r_stall_cnt;

    state_t     w_next_state;
    logic [3:0] w_next_mcnt;
    logic       w_hazard;

`ifdef EX_HAZARD_FWD_EN
    // Load-use check: the lw in EX produces its data too late to forward into ID's consumer
    always_comb begin
        w_hazard = DX_lwFlag && (DX_RD != 5'd0) &&
                   ((DX_RD == fd_rs) || (fd_use_rt && (DX_RD == fd_rt)));
    end

    // Operand A source select; the younger MEM result wins over WB, and $0 is never forwarded
    always_comb begin
        fwd_a = 2'd0;
        if (XM_regwrite && (XM_RD != 5'd0) && (XM_RD == dx_rs)) begin
            fwd_a = 2'd1;
        end else if (MW_regwrite && (MW_RD != 5'd0) && (MW_RD == dx_rs)) begin
            fwd_a = 2'd2;
        end
    end

    // Operand B source select, same priority as operand A
    always_comb begin
        fwd_b = 2'd0;
        if (XM_regwrite && (XM_RD != 5'd0) && (XM_RD == dx_rt)) begin
            fwd_b = 2'd1;
        end else if (MW_regwrite && (MW_RD != 5'd0) && (MW_RD == dx_rt)) begin
            fwd_b = 2'd2;
        end
    end
`else
    logic w_rs_raw;
    logic w_rt_raw;
    logic w_unused_dx;

    // Without forwarding the EX operand indices are not needed
    assign w_unused_dx = ^{dx_rs, dx_rt};

    // RAW check of ID operands against every in-flight write; the EX instruction counts as a writer whenever DX_RD is non-zero
    always_comb begin
        w_rs_raw = (fd_rs != 5'd0) &&
                   ((DX_RD == fd_rs) ||
                    (XM_regwrite && (XM_RD == fd_rs)) ||
                    (MW_regwrite && (MW_RD == fd_rs)));
        w_rt_raw = fd_use_rt && (fd_rt != 5'd0) &&
                   ((DX_RD == fd_rt) ||
                    (XM_regwrite && (XM_RD == fd_rt)) ||
                    (MW_regwrite && (MW_RD == fd_rt)));
        w_hazard = w_rs_raw || w_rt_raw;
    end

    // Forwarding paths are absent, so the ALU always reads the register file
    always_comb begin
        fwd_a = 2'd0;
        fwd_b = 2'd0;
    end
`endif

    // Control decode: branch beats multi-cycle start beats hazard stall; MULWAIT only holds or releases the pipe
    always_comb begin
        pc_stall     = 1'b0;
        fd_stall     = 1'b0;
        fd_flush     = 1'b0;
        dx_bubble    = 1'b0;
        dx_hold      = 1'b0;
        pc_redirect  = 1'b0;
        pc_target    = 32'd0;
        busy         = 1'b0;
        w_next_state = r_state;
        w_next_mcnt  = r_mcnt;
        case (r_state)
            RUN: begin
                if (br_taken) begin
                    pc_redirect = 1'b1;
                    pc_target   = br_target;
                    fd_flush    = 1'b1;
                    dx_bubble   = 1'b1;
                end else if (mul_start) begin
                    pc_stall     = 1'b1;
                    fd_stall     = 1'b1;
                    dx_hold      = 1'b1;
                    busy         = 1'b1;
                    w_next_state = MULWAIT;
                    w_next_mcnt  = 4'(MUL_LAT - 1);
                end else if (w_hazard) begin
                    pc_stall  = 1'b1;
                    fd_stall  = 1'b1;
                    dx_bubble = 1'b1;
                end
            end
            MULWAIT: begin
                busy = 1'b1;
                if (r_mcnt != 4'd1) begin
                    pc_stall    = 1'b1;
                    fd_stall    = 1'b1;
                    dx_hold     = 1'b1;
                    w_next_mcnt = r_mcnt - 4'd1;
                end else begin
                    w_next_state = RUN;
                    w_next_mcnt  = 4'd0;
                end
            end
            default: begin
                w_next_state = RUN;
                w_next_mcnt  = 4'd0;
            end
        endcase
    end

    // State and multi-cycle countdown registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_mcnt  <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_mcnt  <= w_next_mcnt;
        end
    end

    // Stall performance counter, sticks at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (pc_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: directed bench for ex_hazard_ctrl. The counter is
// narrowed to 4 bits so that saturation can be reached quickly. Expected
// values track whether EX_HAZARD_FWD_EN is defined.
module tb_ex_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       fd_rs, fd_rt, dx_rs, dx_rt, DX_RD, XM_RD, MW_RD;
    logic             fd_use_rt, DX_lwFlag, XM_regwrite, MW_regwrite;
    logic             br_taken, mul_start;
    logic [31:0]      br_target;
    logic             pc_stall, fd_stall, fd_flush, dx_bubble, dx_hold, pc_redirect, busy;
    logic [31:0]      pc_target;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    int testsRun = 0;
    int testsFailed = 0;

    // Control bundle: {pc_stall, fd_stall, fd_flush, dx_bubble, dx_hold, pc_redirect, busy}
    logic [6:0] ctrl;
    assign ctrl = {pc_stall, fd_stall, fd_flush, dx_bubble, dx_hold, pc_redirect, busy};

    localparam logic [6:0] C_IDLE   = 7'b0000000;
    localparam logic [6:0] C_LDUSE  = 7'b1101000;
    localparam logic [6:0] C_BRANCH = 7'b0011010;
    localparam logic [6:0] C_MULHLD = 7'b1100101;
    localparam logic [6:0] C_MULEND = 7'b0000001;

    ex_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_use_rt(fd_use_rt),
        .dx_rs(dx_rs), .dx_rt(dx_rt), .DX_RD(DX_RD), .DX_lwFlag(DX_lwFlag),
        .XM_RD(XM_RD), .XM_regwrite(XM_regwrite),
        .MW_RD(MW_RD), .MW_regwrite(MW_regwrite),
        .br_taken(br_taken), .br_target(br_target), .mul_start(mul_start),
        .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush),
        .dx_bubble(dx_bubble), .dx_hold(dx_hold), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Wait for the falling edge, then return every input to an idle pattern
    task automatic applyStimulus();
        @(negedge clk);
        fd_rs = 5'd0; fd_rt = 5'd0; fd_use_rt = 1'b0;
        dx_rs = 5'd0; dx_rt = 5'd0; DX_RD = 5'd0; DX_lwFlag = 1'b0;
        XM_RD = 5'd0; XM_regwrite = 1'b0; MW_RD = 5'd0; MW_regwrite = 1'b0;
        br_taken = 1'b0; br_target = 32'd0; mul_start = 1'b0;
    endtask

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        fd_rs = 5'd0; fd_rt = 5'd0; fd_use_rt = 1'b0;
        dx_rs = 5'd0; dx_rt = 5'd0; DX_RD = 5'd0; DX_lwFlag = 1'b0;
        XM_RD = 5'd0; XM_regwrite = 1'b0; MW_RD = 5'd0; MW_regwrite = 1'b0;
        br_taken = 1'b0; br_target = 32'd0; mul_start = 1'b0;
        #1;
        checkOutput("reset_ctrl", 32'(ctrl), 32'(C_IDLE));
        checkOutput("reset_target", pc_target, 32'd0);
        checkOutput("reset_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("reset_fwd", 32'({fwd_a, fwd_b}), 32'd0);

        applyStimulus();
        rst = 1'b0;
        #1 checkOutput("idle_ctrl", 32'(ctrl), 32'(C_IDLE));

        // Load-use on rs stalls exactly one cycle
        applyStimulus();
        DX_lwFlag = 1'b1; DX_RD = 5'd5; fd_rs = 5'd5;
        #1 checkOutput("lduse_rs_ctrl", 32'(ctrl), 32'(C_LDUSE));
        applyStimulus();
        #1 checkOutput("lduse_after_ctrl", 32'(ctrl), 32'(C_IDLE));
        checkOutput("lduse_cnt", 32'(stall_cnt), 32'd1);

        // Register 0 never creates a hazard
        applyStimulus();
        DX_lwFlag = 1'b1; DX_RD = 5'd0; fd_rs = 5'd0;
        #1 checkOutput("lduse_r0_ctrl", 32'(ctrl), 32'(C_IDLE));

        // rt match only matters when the ID instruction reads rt
        applyStimulus();
        DX_lwFlag = 1'b1; DX_RD = 5'd9; fd_rt = 5'd9; fd_rs = 5'd3; fd_use_rt = 1'b0;
        #1 checkOutput("lduse_rt_unused", 32'(ctrl), 32'(C_IDLE));
        applyStimulus();
        DX_lwFlag = 1'b1; DX_RD = 5'd9; fd_rt = 5'd9; fd_rs = 5'd3; fd_use_rt = 1'b1;
        #1 checkOutput("lduse_rt_used", 32'(ctrl), 32'(C_LDUSE));

        // Taken branch outranks a simultaneous load-use
        applyStimulus();
        checkOutput("cnt_before_br", 32'(stall_cnt), 32'd2);
        br_taken = 1'b1; br_target = 32'h40;
        DX_lwFlag = 1'b1; DX_RD = 5'd5; fd_rs = 5'd5;
        #1 checkOutput("br_ctrl", 32'(ctrl), 32'(C_BRANCH));
        checkOutput("br_target", pc_target, 32'h40);
        applyStimulus();
        #1 checkOutput("br_after_ctrl", 32'(ctrl), 32'(C_IDLE));
        checkOutput("br_after_target", pc_target, 32'd0);
        checkOutput("br_cnt", 32'(stall_cnt), 32'd2);

        // Multi-cycle op outranks load-use; branch ignored while waiting
        applyStimulus();
        mul_start = 1'b1;
        DX_lwFlag = 1'b1; DX_RD = 5'd5; fd_rs = 5'd5;
        #1 checkOutput("mul_c0_ctrl", 32'(ctrl), 32'(C_MULHLD));
        for (int i = 1; i <= 2; i++) begin
            applyStimulus();
            mul_start = 1'b1; br_taken = 1'b1; br_target = 32'h80;
            #1 checkOutput($sformatf("mul_c%0d_ctrl", i), 32'(ctrl), 32'(C_MULHLD));
            checkOutput($sformatf("mul_c%0d_target", i), pc_target, 32'd0);
        end
        applyStimulus();
        mul_start = 1'b1; br_taken = 1'b1; br_target = 32'h80;
        #1 checkOutput("mul_c3_ctrl", 32'(ctrl), 32'(C_MULEND));
        checkOutput("mul_c3_target", pc_target, 32'd0);
        applyStimulus();
        #1 checkOutput("mul_done_ctrl", 32'(ctrl), 32'(C_IDLE));
        checkOutput("mul_cnt", 32'(stall_cnt), 32'd5);

        // Counter saturates at all-ones: 5 + 14 stall cycles must read 15
        for (int i = 0; i < 14; i++) begin
            applyStimulus();
            DX_lwFlag = 1'b1; DX_RD = 5'd6; fd_rs = 5'd6;
        end
        applyStimulus();
        #1 checkOutput("cnt_saturate", 32'(stall_cnt), 32'd15);

        // Asynchronous reset in the middle of a multi-cycle wait
        applyStimulus();
        mul_start = 1'b1;
        applyStimulus();
        #1 checkOutput("mulrst_pre_ctrl", 32'(ctrl), 32'(C_MULHLD));
        #2 rst = 1'b1;
        #1 checkOutput("mulrst_ctrl", 32'(ctrl), 32'(C_IDLE));
        checkOutput("mulrst_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("mulrst_target", pc_target, 32'd0);
        applyStimulus();
        rst = 1'b0;
        #1 checkOutput("mulrst_rel_ctrl", 32'(ctrl), 32'(C_IDLE));
        applyStimulus();
        #1 checkOutput("mulrst_run_ctrl", 32'(ctrl), 32'(C_IDLE));

`ifdef EX_HAZARD_FWD_EN
        // MEM result beats WB result
        applyStimulus();
        XM_RD = 5'd7; XM_regwrite = 1'b1; MW_RD = 5'd7; MW_regwrite = 1'b1; dx_rs = 5'd7;
        #1 checkOutput("fwd_a_xm", 32'(fwd_a), 32'd1);
        checkOutput("fwd_b_none", 32'(fwd_b), 32'd0);
        applyStimulus();
        XM_RD = 5'd7; XM_regwrite = 1'b0; MW_RD = 5'd7; MW_regwrite = 1'b1; dx_rs = 5'd7; dx_rt = 5'd7;
        #1 checkOutput("fwd_a_mw", 32'(fwd_a), 32'd2);
        checkOutput("fwd_b_mw", 32'(fwd_b), 32'd2);
        applyStimulus();
        XM_RD = 5'd0; XM_regwrite = 1'b1; MW_RD = 5'd0; MW_regwrite = 1'b1; dx_rs = 5'd0; dx_rt = 5'd0;
        #1 checkOutput("fwd_r0", 32'({fwd_a, fwd_b}), 32'd0);
        applyStimulus();
        XM_RD = 5'd4; XM_regwrite = 1'b1; MW_RD = 5'd8; MW_regwrite = 1'b1; dx_rs = 5'd8; dx_rt = 5'd4;
        fd_rs = 5'd4;
        #1 checkOutput("fwd_split", 32'({fwd_a, fwd_b}), 32'({2'd2, 2'd1}));
        checkOutput("fwd_nostall", 32'(ctrl), 32'(C_IDLE));
        applyStimulus();
        #1 checkOutput("fwd_cnt", 32'(stall_cnt), 32'd0);
`else
        // No forwarding: ID operands stall on any pending write
        applyStimulus();
        XM_RD = 5'd7; XM_regwrite = 1'b1; MW_RD = 5'd7; MW_regwrite = 1'b1; dx_rs = 5'd7; fd_rs = 5'd7;
        #1 checkOutput("raw_xm_ctrl", 32'(ctrl), 32'(C_LDUSE));
        checkOutput("raw_fwd_zero", 32'({fwd_a, fwd_b}), 32'd0);
        applyStimulus();
        MW_RD = 5'd7; MW_regwrite = 1'b1; fd_rt = 5'd7; fd_use_rt = 1'b1; dx_rt = 5'd7;
        #1 checkOutput("raw_mw_ctrl", 32'(ctrl), 32'(C_LDUSE));
        checkOutput("raw_mw_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        applyStimulus();
        XM_RD = 5'd7; MW_RD = 5'd7; fd_rs = 5'd7;
        #1 checkOutput("raw_nowrite", 32'(ctrl), 32'(C_IDLE));
        applyStimulus();
        XM_RD = 5'd0; XM_regwrite = 1'b1; fd_rs = 5'd0;
        #1 checkOutput("raw_r0", 32'(ctrl), 32'(C_IDLE));
        applyStimulus();
        #1 checkOutput("raw_cnt", 32'(stall_cnt), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
